// File: rtl/nic_cpu_sequencer_if.sv
// rtl/nic_cpu_sequencer_if.sv - requester/consumer streams plus NIC processor-side register port
interface nic_cpu_sequencer_if #(
    parameter int PACKET_WIDTH = 64,
    parameter int CNT_WIDTH    = 16
);
    logic                    tx_valid;
    logic                    tx_ready;
    logic [PACKET_WIDTH-1:0] tx_data;
    logic                    rx_valid;
    logic                    rx_ready;
    logic [PACKET_WIDTH-1:0] rx_data;
    logic [1:0]              addr;
    logic [PACKET_WIDTH-1:0] d_out;
    logic [PACKET_WIDTH-1:0] d_in;
    logic                    nicEn;
    logic                    nicEnWR;
    logic [CNT_WIDTH-1:0]    tx_count;
    logic [CNT_WIDTH-1:0]    rx_count;
    logic                    busy;

    modport master (
        input  tx_valid, tx_data, rx_ready, d_in,
        output tx_ready, rx_valid, rx_data, addr, d_out, nicEn, nicEnWR,
               tx_count, rx_count, busy
    );

    modport slave (
        output tx_valid, tx_data, rx_ready, d_in,
        input  tx_ready, rx_valid, rx_data, addr, d_out, nicEn, nicEnWR,
               tx_count, rx_count, busy
    );
endinterface

// File: rtl/nic_cpu_sequencer.sv
// rtl/nic_cpu_sequencer.sv - round-robin TX/RX sequencer that polls NIC status before each buffer access
module nic_cpu_sequencer #(
    parameter int PACKET_WIDTH = 64,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                clk,
    input  logic                reset,
    nic_cpu_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, RX_STAT, RX_STAT_W, RX_RD, RX_RD_W, TX_STAT, TX_STAT_W, TX_WR
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_last_rx;
    logic                    r_tx_ready;
    logic                    r_rx_valid;
    logic                    r_nic_en;
    logic                    r_nic_wr;
    logic                    r_busy;
    logic [1:0]              r_addr;
    logic [PACKET_WIDTH-1:0] r_rx_data;
    logic [PACKET_WIDTH-1:0] r_d_out_hold;
    logic [CNT_WIDTH-1:0]    r_tx_count;
    logic [CNT_WIDTH-1:0]    r_rx_count;
    logic                    w_tx_elig;
    logic                    w_rx_elig;

    assign w_tx_elig = bus.tx_valid;
    assign w_rx_elig = !r_rx_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_tx_elig && w_rx_elig) w_next = r_last_rx ? TX_STAT : RX_STAT;
                else if (w_tx_elig)         w_next = TX_STAT;
                else if (w_rx_elig)         w_next = RX_STAT;
            end
            RX_STAT:   w_next = RX_STAT_W;
            RX_STAT_W: w_next = bus.d_in[0] ? RX_RD : IDLE;
            RX_RD:     w_next = RX_RD_W;
            RX_RD_W:   w_next = IDLE;
            TX_STAT:   w_next = TX_STAT_W;
            TX_STAT_W: w_next = bus.d_in[0] ? IDLE : TX_WR;
            TX_WR:     w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // NIC strobes are registered from the next state so no input reaches the NIC port combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_rx    <= 1'b0;
            r_tx_ready   <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_nic_en     <= 1'b0;
            r_nic_wr     <= 1'b0;
            r_busy       <= 1'b0;
            r_addr       <= 2'b00;
            r_rx_data    <= '0;
            r_d_out_hold <= '0;
            r_tx_count   <= '0;
            r_rx_count   <= '0;
        end else begin
            r_state    <= w_next;
            r_busy     <= (w_next != IDLE);
            r_nic_en   <= (w_next inside {RX_STAT, RX_RD, TX_STAT, TX_WR});
            r_nic_wr   <= (w_next == TX_WR);
            r_tx_ready <= (w_next == TX_WR);
            case (w_next)
                RX_STAT: r_addr <= 2'b01;
                TX_STAT: r_addr <= 2'b11;
                TX_WR:   r_addr <= 2'b10;
                default: r_addr <= 2'b00;
            endcase

            if (r_state == RX_STAT_W && !bus.d_in[0]) r_last_rx <= 1'b1;
            if (r_state == TX_STAT_W && bus.d_in[0])  r_last_rx <= 1'b0;

            if (r_state == RX_RD_W) begin
                r_rx_data  <= bus.d_in;
                r_rx_valid <= 1'b1;
                r_rx_count <= r_rx_count + 1'b1;
                r_last_rx  <= 1'b1;
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            if (r_state == TX_WR) begin
                r_d_out_hold <= bus.tx_data;
                r_tx_count   <= r_tx_count + 1'b1;
                r_last_rx    <= 1'b0;
            end
        end
    end

    // tx_data is only looked at while in TX_WR; afterwards the written word is held.
    assign bus.d_out    = (r_state == TX_WR) ? bus.tx_data : r_d_out_hold;
    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;
    assign bus.addr     = r_addr;
    assign bus.nicEn    = r_nic_en;
    assign bus.nicEnWR  = r_nic_wr;
    assign bus.tx_count = r_tx_count;
    assign bus.rx_count = r_rx_count;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_nic_cpu_sequencer.sv
// tb/tb_nic_cpu_sequencer.sv - directed bench for nic_cpu_sequencer with a behavioural NIC register model
`timescale 1ns/1ps
module tb_nic_cpu_sequencer;
    localparam int PW = 64;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nic_cpu_sequencer_if #(.PACKET_WIDTH(PW), .CNT_WIDTH(CW)) bus ();
    nic_cpu_sequencer #(.PACKET_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_wr = 0, n_in_stat = 0, n_in_rd = 0, n_out_stat = 0;
    int in_avail = 0, out_block_until = 0;
    logic [PW-1:0] in_data = '0;
    logic [PW-1:0] last_wr_data = '0;
    logic [1:0]    last_wr_addr = 2'b00;

    // NIC: read data appears the cycle after the strobe; status bit 0 = buffer full.
    always @(posedge clk) begin
        if (bus.nicEn && !bus.nicEnWR) begin
            case (bus.addr)
                2'b00: begin
                    bus.d_in <= in_data;
                    n_in_rd  <= n_in_rd + 1;
                end
                2'b01: begin
                    bus.d_in  <= {{(PW-1){1'b0}}, (in_avail > n_in_rd)};
                    n_in_stat <= n_in_stat + 1;
                end
                2'b10: bus.d_in <= '0;
                default: begin
                    bus.d_in   <= {{(PW-1){1'b0}}, (n_out_stat < out_block_until)};
                    n_out_stat <= n_out_stat + 1;
                end
            endcase
        end
        if (bus.nicEn && bus.nicEnWR) begin
            n_wr         <= n_wr + 1;
            last_wr_data <= bus.d_out;
            last_wr_addr <= bus.addr;
        end
    end

    int n_cmp = 0, n_bad = 0;
    logic found;
    int lat, nev, ntx, snap_a, snap_b;
    logic prev_rv;
    int ev_kind [4];
    int ev_time [4];
    int exp_kind [4] = '{1, 0, 1, 0};
    int exp_time [4] = '{5, 8, 14, 17};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rx_valid"}, 64'(bus.rx_valid), 0);
        check({tag, "_rx_data"},  bus.rx_data, 0);
        check({tag, "_tx_ready"}, 64'(bus.tx_ready), 0);
        check({tag, "_nicEn"},    64'(bus.nicEn), 0);
        check({tag, "_nicEnWR"},  64'(bus.nicEnWR), 0);
        check({tag, "_addr"},     64'(bus.addr), 0);
        check({tag, "_d_out"},    bus.d_out, 0);
        check({tag, "_tx_count"}, 64'(bus.tx_count), 0);
        check({tag, "_rx_count"}, 64'(bus.rx_count), 0);
        check({tag, "_busy"},     64'(bus.busy), 0);
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.rx_ready = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("por");

        // Reset in TX_STAT_W: RX wins the first tie (failed poll), then TX polls.
        bus.tx_valid = 1'b1;
        bus.tx_data  = 64'h1111_2222_3333_4444;
        reset = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (bus.nicEn && bus.addr == 2'b11) found = 1'b1;
        end
        check("midtx_reach_tx_stat", 64'(found), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset("midtx");
        bus.tx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("midtx_no_write", 64'(n_wr), 0);
        check("midtx_tx_count", 64'(bus.tx_count), 0);

        // RX held while consumer stalls.
        in_data  = 64'h0123_4567_89AB_CDEF;
        in_avail = n_in_rd + 1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (bus.rx_valid) found = 1'b1;
        end
        check("rx_valid_rise", 64'(found), 1);
        check("rx_data", bus.rx_data, 64'h0123_4567_89AB_CDEF);
        check("rx_count", 64'(bus.rx_count), 1);
        snap_a   = n_in_stat;
        snap_b   = n_in_rd;
        in_avail = n_in_rd + 1;
        repeat (10) @(negedge clk);
        check("rx_valid_held", 64'(bus.rx_valid), 1);
        check("rx_data_held", bus.rx_data, 64'h0123_4567_89AB_CDEF);
        check("rx_no_stat_poll", 64'(n_in_stat - snap_a), 0);
        check("rx_no_buf_read", 64'(n_in_rd - snap_b), 0);
        check("rx_idle_busy", 64'(bus.busy), 0);

        // Single TX, cycle by cycle (RX ineligible while holding register full).
        bus.tx_data  = 64'hDEAD_BEEF_0000_0001;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        check("tx1_c2_en", 64'(bus.nicEn), 1);
        check("tx1_c2_addr", 64'(bus.addr), 3);
        check("tx1_c2_wr", 64'(bus.nicEnWR), 0);
        @(negedge clk);
        check("tx1_c3_en", 64'(bus.nicEn), 0);
        check("tx1_c3_busy", 64'(bus.busy), 1);
        @(negedge clk);
        check("tx1_c4_ready", 64'(bus.tx_ready), 1);
        check("tx1_c4_en", 64'(bus.nicEn), 1);
        check("tx1_c4_wr", 64'(bus.nicEnWR), 1);
        check("tx1_c4_addr", 64'(bus.addr), 2);
        check("tx1_c4_d_out", bus.d_out, 64'hDEAD_BEEF_0000_0001);
        check("tx1_c4_count", 64'(bus.tx_count), 0);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        bus.tx_data = '0;
        #1;
        check("tx1_ready_drop", 64'(bus.tx_ready), 0);
        check("tx1_count", 64'(bus.tx_count), 1);
        check("tx1_d_out_hold", bus.d_out, 64'hDEAD_BEEF_0000_0001);
        check("tx1_nic_writes", 64'(n_wr), 1);
        check("tx1_nic_data", last_wr_data, 64'hDEAD_BEEF_0000_0001);
        check("tx1_nic_addr", 64'(last_wr_addr), 2);
        check("tx1_busy", 64'(bus.busy), 0);

        // TX blocked by a full output buffer for three polls.
        out_block_until = n_out_stat + 3;
        snap_a = n_wr;
        snap_b = n_out_stat;
        bus.tx_data  = 64'hCAFE_F00D_0000_0002;
        bus.tx_valid = 1'b1;
        found = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(negedge clk);
            if (bus.tx_ready) begin
                found = 1'b1;
                lat = k;
            end
        end
        bus.tx_valid = 1'b0;
        check("blk_found", 64'(found), 1);
        check("blk_latency", 64'(lat), 12);
        @(negedge clk);
        check("blk_writes", 64'(n_wr - snap_a), 1);
        check("blk_polls", 64'(n_out_stat - snap_b), 4);
        check("blk_tx_count", 64'(bus.tx_count), 2);
        check("blk_nic_data", last_wr_data, 64'hCAFE_F00D_0000_0002);

        // Tie arbitration from reset: RX, TX, RX, TX with no extra bubbles.
        reset = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 64'h5555_AAAA_5555_AAAA;
        bus.rx_ready = 1'b1;
        in_avail = n_in_rd + 100;
        out_block_until = n_out_stat;
        @(negedge clk);
        reset = 1'b1;
        nev = 0;
        prev_rv = 1'b0;
        for (int k = 1; k <= 60 && nev < 4; k++) begin
            @(negedge clk);
            if (bus.rx_valid && !prev_rv) begin
                ev_kind[nev] = 1;
                ev_time[nev] = k;
                nev++;
            end else if (bus.tx_ready) begin
                ev_kind[nev] = 0;
                ev_time[nev] = k;
                nev++;
            end
            prev_rv = bus.rx_valid;
            if (nev == 4) bus.tx_valid = 1'b0;
        end
        in_avail = n_in_rd;
        check("tie_events", 64'(nev), 4);
        for (int i = 0; i < 4 && i < nev; i++) begin
            check($sformatf("tie_kind_%0d", i), 64'(ev_kind[i]), 64'(exp_kind[i]));
            check($sformatf("tie_time_%0d", i), 64'(ev_time[i]), 64'(exp_time[i]));
        end
        @(negedge clk);
        check("tie_tx_count", 64'(bus.tx_count), 2);
        check("tie_rx_count", 64'(bus.rx_count), 2);

        // Counter wrap at CNT_WIDTH=4 over 17 writes.
        reset = 1'b0;
        bus.tx_valid = 1'b1;
        out_block_until = n_out_stat;
        @(negedge clk);
        reset = 1'b1;
        ntx = 0;
        for (int k = 0; k < 400 && ntx < 17; k++) begin
            @(negedge clk);
            if (bus.tx_ready) begin
                ntx++;
                if (ntx == 17) bus.tx_valid = 1'b0;
                @(negedge clk);
                check($sformatf("wrap_tx_count_%0d", ntx), 64'(bus.tx_count), 64'(ntx % 16));
            end
        end
        check("wrap_done", 64'(ntx), 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nic_cpu_sequencer.md
# nic_cpu_sequencer

Per-node controller that replaces the dummy CPU in front of each NIC. It sequences the NIC's processor-side register port (addr, d_in, d_out, nicEn, nicEnWR). It arbitrates round-robin between a transmit requester, which pushes packets toward the router's PE port, and a receive consumer, which drains packets the NIC has collected. It polls the NIC status registers before every buffer access, so it never writes a full output buffer or reads an empty input buffer. One instance sits between each node's processing logic and its `nic` inside the mesh.

## Interface
- PACKET_WIDTH, 64, NIC data/packet width in bits
- CNT_WIDTH, 16, width of the tx/rx packet counters

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- tx_valid  in  1  requester has a packet on tx_data
- tx_ready  out  1  one-cycle pulse: tx_data accepted and written to NIC
- tx_data  in  PACKET_WIDTH  packet to send, held stable while tx_valid=1
- rx_valid  out  1  rx_data holds a received packet
- rx_ready  in  1  consumer takes rx_data when rx_valid & rx_ready
- rx_data  out  PACKET_WIDTH  received packet holding register
- addr  out  2  NIC register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status
- d_out  out  PACKET_WIDTH  write data to NIC
- d_in  in  PACKET_WIDTH  read data from NIC, valid the cycle after a read strobe
- nicEn  out  1  NIC access strobe, one cycle per access
- nicEnWR  out  1  1 = write, 0 = read; qualified by nicEn
- tx_count  out  CNT_WIDTH  packets written to NIC output buffer, wraps
- rx_count  out  CNT_WIDTH  packets read from NIC input buffer, wraps
- busy  out  1  FSM not in IDLE

## Operation
- Status register semantics: d_in[0] = 1 means the buffer is full. Input status full means a packet is waiting. Output status full means no room.
- Eligibility:
  - TX is eligible when tx_valid=1.
  - RX is eligible when rx_valid=0, i.e. the holding register is empty.
- Arbitration in IDLE:
  - Only one eligible: serve it.
  - Both eligible: serve the one not served last. The 1-bit last_served flag resets to TX, so RX wins the first tie.
  - Neither eligible: remain in IDLE.
- States:
  - IDLE: arbitrate as above.
  - RX_STAT: drive addr=01, nicEn=1, nicEnWR=0. Go to RX_STAT_W.
  - RX_STAT_W: sample d_in[0]. If 1, go to RX_RD. If 0, go to IDLE (nothing waiting; last_served=RX).
  - RX_RD: drive addr=00, nicEn=1, nicEnWR=0. Go to RX_RD_W.
  - RX_RD_W: capture d_in into rx_data, set rx_valid=1, increment rx_count, set last_served=RX. Go to IDLE.
  - TX_STAT: drive addr=11, nicEn=1, nicEnWR=0. Go to TX_STAT_W.
  - TX_STAT_W: sample d_in[0]. If 0, go to TX_WR. If 1, go to IDLE with last_served=TX, so a pending RX is served before TX retries.
  - TX_WR: drive addr=10, d_out=tx_data, nicEn=1, nicEnWR=1, tx_ready=1. Increment tx_count, set last_served=TX. Go to IDLE.
- rx_valid clears on the cycle after rx_valid & rx_ready. RX becomes eligible again from that cycle.
- nicEn is asserted only in RX_STAT, RX_RD, TX_STAT and TX_WR. In all other states nicEn=0, nicEnWR=0, addr=00 and d_out holds its last value.
- tx_data must not be sampled except in TX_WR. Deasserting tx_valid mid-sequence is illegal; behaviour is undefined.
- Counters are plain modulo 2^CNT_WIDTH incrementers. 0xFFFF wraps to 0x0000 at the default width.

## Timing
- Reset (reset=0, asynchronous):
  - State = IDLE, last_served = TX.
  - Outputs: rx_valid=0, rx_data=0, tx_ready=0, nicEn=0, nicEnWR=0, addr=00, d_out=0, tx_count=0, rx_count=0, busy=0.
- Reset deassertion takes effect at the next rising edge. Reset asserted mid-sequence aborts immediately, and no partial write is issued after release.
- Successful TX takes 4 cycles: IDLE, TX_STAT, TX_STAT_W, TX_WR. tx_ready pulses in the 4th cycle, counting from the cycle IDLE sees tx_valid.
- Successful RX takes 5 cycles: IDLE, RX_STAT, RX_STAT_W, RX_RD, RX_RD_W. rx_valid rises on the edge ending RX_RD_W.
- Failed poll takes 3 cycles, then IDLE.
- Sustained bidirectional traffic alternates TX/RX sequences with no extra bubbles beyond the IDLE cycle.
- All outputs are registered or decoded from the state register only. There is no combinational path from tx_valid/rx_ready to NIC outputs.

## Test plan
- Reset mid-TX: assert reset=0 during TX_STAT_W, then release. Required: all outputs at reset values, no nicEnWR=1 strobe, tx_count=0.
- Single TX, NIC output status d_in[0]=0, tx_data=64'hDEAD_BEEF_0000_0001. Required: addr=11 read strobe, then addr=10 write with d_out=tx_data, tx_ready pulse in cycle 4, tx_count=1.
- TX blocked, output status full for 3 polls then empty. Required: 3 aborted 3-cycle sequences with no write strobe, then one write, tx_count=1.
- RX, input status full, d_in=64'h0123_4567_89AB_CDEF on buffer read, rx_ready=0 for 10 cycles. Required: rx_valid=1 with that data held. No further addr=01/00 strobes until rx_ready handshake. rx_count=1.
- Tie arbitration: tx_valid=1 and input status full from reset. Required: order RX, TX, RX, TX. Counters increment alternately.
- Counter wrap with CNT_WIDTH=4: 17 successful TX. Required: tx_count sequence reaches 15, then 0, then 1.
